// File: rtl/wb_stage_if.sv
// Writeback-stage bus: ALU and load-return inputs, decode read ports, and the
// registered RegFile write port with stall/err back to the pipeline.
interface wb_stage_if;
    logic       alu_valid;
    logic [2:0] alu_dest;
    logic [7:0] alu_result;
    logic       ld_issue;
    logic [2:0] ld_dest;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic [2:0] rd_reg1;
    logic [2:0] rd_reg2;
    logic       regWrite;
    logic [2:0] writeReg;
    logic [7:0] writeData;
    logic       stall;
    logic       err;

    // Pipeline side that drives results and read addresses.
    modport master (
        output alu_valid, alu_dest, alu_result,
        output ld_issue, ld_dest, mem_rvalid, mem_rdata,
        output rd_reg1, rd_reg2,
        input  regWrite, writeReg, writeData, stall, err
    );

    // Writeback stage itself.
    modport slave (
        input  alu_valid, alu_dest, alu_result,
        input  ld_issue, ld_dest, mem_rvalid, mem_rdata,
        input  rd_reg1, rd_reg2,
        output regWrite, writeReg, writeData, stall, err
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: tracks one outstanding load, merges load returns and ALU
// results through an in-order pending-write FIFO into a single RegFile port.
module wb_stage #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0] dest;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } ld_state_t;

    ld_state_t       state;
    logic [2:0]      ld_dest_q;
    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            wr_en_q;
    logic [2:0]      wr_reg_q;
    logic [7:0]      wr_data_q;
    logic            err_q;

    logic            ld_ret;
    logic            proto_err;
    entry_t          ld_ent;
    entry_t          alu_ent;
    entry_t          cand0;
    entry_t          cand1;
    logic [1:0]      cand_n;
    logic            pop;
    logic            out_valid;
    entry_t          out_ent;
    entry_t          enq0;
    entry_t          enq1;
    logic [1:0]      enq_n;
    logic [CW-1:0]   space;
    logic [1:0]      acc_n;
    logic            drop;
    logic [7:0]      busy;

    // Ordering: a same-cycle load return always precedes the ALU result. The
    // FIFO head wins the write port; otherwise the first new event bypasses.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        alu_ent.dest = bus.alu_dest;
        alu_ent.data = bus.alu_result;
        ld_ent.dest  = ld_dest_q;
        ld_ent.data  = bus.mem_rdata;
        enq0         = alu_ent;
        enq1         = alu_ent;
        enq_n        = 2'd0;
        acc_n        = 2'd0;

        ld_ret    = (state == WAIT_MEM) && bus.mem_rvalid;
        proto_err = ((state == IDLE) && bus.mem_rvalid) ||
                    ((state == WAIT_MEM) && bus.ld_issue && !bus.mem_rvalid);

        cand0  = ld_ret ? ld_ent : alu_ent;
        cand1  = alu_ent;
        cand_n = 2'(ld_ret) + 2'(bus.alu_valid);

        pop       = (count != '0);
        out_valid = pop || (cand_n != 2'd0);
        out_ent   = pop ? fifo_mem[rd_ptr] : cand0;

        if (pop) begin
            enq0  = cand0;
            enq1  = cand1;
            enq_n = cand_n;
        end else begin
            enq0  = cand1;
            enq_n = (cand_n == 2'd2) ? 2'd1 : 2'd0;
        end

        space = CW'(DEPTH) - (count - CW'(pop));
        if (space >= CW'(enq_n)) acc_n = enq_n;
        else                     acc_n = space[1:0];
        drop = (acc_n != enq_n);
    end

    // Destinations with a write still in flight: queued, in the output
    // register, or the load we are waiting on.
    always_comb begin
        busy = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) busy[fifo_mem[rd_ptr + AW'(i)].dest] = 1'b1;
        end
        if (wr_en_q)            busy[wr_reg_q]  = 1'b1;
        if (state == WAIT_MEM)  busy[ld_dest_q] = 1'b1;
    end

    assign bus.stall = (count >= CW'(DEPTH - 1)) ||
                       busy[bus.rd_reg1] || busy[bus.rd_reg2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_dest_q <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_issue) begin
                        state     <= WAIT_MEM;
                        ld_dest_q <= bus.ld_dest;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        if (bus.ld_issue) ld_dest_q <= bus.ld_dest;
                        else              state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (proto_err || drop) err_q <= 1'b1;

            wr_en_q <= out_valid;
            if (out_valid) begin
                wr_reg_q  <= out_ent.dest;
                wr_data_q <= out_ent.data;
            end

            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(acc_n);
            count  <= count - CW'(pop) + CW'(acc_n);
        end
    end

    // NOTE: FIFO storage has no reset; count alone defines which slots are
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (acc_n != 2'd0) fifo_mem[wr_ptr]          <= enq0;
            if (acc_n == 2'd2) fifo_mem[wr_ptr + AW'(1)] <= enq1;
        end
    end

    assign bus.regWrite  = wr_en_q;
    assign bus.writeReg  = wr_reg_q;
    assign bus.writeData = wr_data_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: bypass latency, load hazards, ordering,
// FIFO overflow and error/reset behaviour against hand-computed values.
module tb_wb_stage;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] rf [8];

    // Overflow scenario: expected write order and per-step stall/err.
    logic [2:0] exp_dest  [10] = '{3'd1, 3'd7, 3'd2, 3'd7, 3'd3, 3'd7, 3'd4, 3'd7, 3'd5, 3'd6};
    logic [7:0] exp_data  [10] = '{8'h10, 8'h21, 8'h11, 8'h22, 8'h12, 8'h23, 8'h13, 8'h24, 8'h14, 8'h15};
    logic       exp_stall [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_err   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    wb_stage_if bus ();

    wb_stage #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny RegFile fed by the write port.
    always @(posedge clk) begin
        if (bus.regWrite) rf[bus.writeReg] <= bus.writeData;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_dest   = 3'd0;
        bus.alu_result = 8'h00;
        bus.ld_issue   = 1'b0;
        bus.ld_dest    = 3'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        bus.rd_reg1 = 3'd0;
        bus.rd_reg2 = 3'd0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_regWrite",  bus.regWrite,  0);
        check("rst_writeReg",  bus.writeReg,  0);
        check("rst_writeData", bus.writeData, 0);
        check("rst_err",       bus.err,       0);
        check("rst_stall",     bus.stall,     0);
        rst_n = 1'b1;

        // ALU bypass: one-cycle latency, then hold when idle.
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd3; bus.alu_result = 8'h5A;
        tick();
        clear_inputs();
        check("alu_regWrite",  bus.regWrite,  1);
        check("alu_writeReg",  bus.writeReg,  3);
        check("alu_writeData", bus.writeData, 8'h5A);
        tick();
        check("alu_idle_regWrite", bus.regWrite,  0);
        check("alu_hold_writeReg", bus.writeReg,  3);
        check("alu_hold_data",     bus.writeData, 8'h5A);
        check("alu_rf3",           rf[3],         8'h5A);

        // Load to r5: hazard while outstanding and while in output register.
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd5;
        tick();
        clear_inputs();
        bus.rd_reg1 = 3'd5;
        #1;
        check("ld_wait_stall", bus.stall, 1);
        bus.rd_reg1 = 3'd4;
        #1;
        check("ld_other_nostall", bus.stall, 0);
        bus.rd_reg1 = 3'd5;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hC3;
        tick();
        clear_inputs();
        check("ld_regWrite",    bus.regWrite,  1);
        check("ld_writeReg",    bus.writeReg,  5);
        check("ld_writeData",   bus.writeData, 8'hC3);
        check("ld_outreg_stall", bus.stall,    1);
        tick();
        check("ld_done_stall", bus.stall, 0);
        check("ld_rf5",        rf[5],     8'hC3);
        check("ld_err",        bus.err,   0);
        bus.rd_reg1 = 3'd0;

        // Same-edge load return and ALU result: load first.
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd2;
        tick();
        clear_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h11;
        bus.alu_valid = 1'b1;  bus.alu_dest = 3'd4; bus.alu_result = 8'h22;
        tick();
        clear_inputs();
        check("ord1_writeReg",  bus.writeReg,  2);
        check("ord1_writeData", bus.writeData, 8'h11);
        tick();
        check("ord2_regWrite",  bus.regWrite,  1);
        check("ord2_writeReg",  bus.writeReg,  4);
        check("ord2_writeData", bus.writeData, 8'h22);
        tick();
        check("ord_idle_regWrite", bus.regWrite, 0);
        check("ord_rf2", rf[2], 8'h11);
        check("ord_rf4", rf[4], 8'h22);

        // Overflow: ALU + load return every cycle for 6 cycles, then drain.
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            bus.alu_valid  = 1'b1;
            bus.alu_dest   = 3'd7;
            bus.alu_result = 8'h20 + 8'(k);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 8'h10 + 8'(k - 1);
            bus.ld_issue   = (k <= 5);
            bus.ld_dest    = 3'(k + 1);
            tick();
            check($sformatf("ovf%0d_regWrite", k - 1),  bus.regWrite,  1);
            check($sformatf("ovf%0d_writeReg", k - 1),  bus.writeReg,  exp_dest[k - 1]);
            check($sformatf("ovf%0d_writeData", k - 1), bus.writeData, exp_data[k - 1]);
            check($sformatf("ovf%0d_stall", k - 1),     bus.stall,     exp_stall[k - 1]);
            check($sformatf("ovf%0d_err", k - 1),       bus.err,       exp_err[k - 1]);
        end
        clear_inputs();
        for (int s = 6; s < 10; s++) begin
            tick();
            check($sformatf("ovf%0d_regWrite", s),  bus.regWrite,  1);
            check($sformatf("ovf%0d_writeReg", s),  bus.writeReg,  exp_dest[s]);
            check($sformatf("ovf%0d_writeData", s), bus.writeData, exp_data[s]);
            check($sformatf("ovf%0d_stall", s),     bus.stall,     exp_stall[s]);
            check($sformatf("ovf%0d_err", s),       bus.err,       exp_err[s]);
        end
        tick();
        check("ovf_drained_regWrite", bus.regWrite, 0);

        // Reset clears err; stray mem_rvalid sets it and it sticks.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_err", bus.err, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hEE;
        tick();
        clear_inputs();
        check("stray_regWrite", bus.regWrite, 0);
        check("stray_err",      bus.err,      1);
        tick();
        check("stray_err_sticky", bus.err, 1);

        // Reset overrides a same-cycle ALU result.
        rst_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd6; bus.alu_result = 8'h77;
        bus.rd_reg1 = 3'd6;
        tick();
        clear_inputs();
        rst_n = 1'b1;
        check("rst3_err",       bus.err,       0);
        check("rst3_regWrite",  bus.regWrite,  0);
        check("rst3_writeReg",  bus.writeReg,  0);
        check("rst3_writeData", bus.writeData, 0);
        check("rst3_stall",     bus.stall,     0);

        // Reset mid-load discards it; the late return is an error.
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd3;
        tick();
        clear_inputs();
        bus.rd_reg1 = 3'd3;
        #1;
        check("midld_stall", bus.stall, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midld_rst_stall", bus.stall, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h99;
        tick();
        clear_inputs();
        check("midld_late_regWrite", bus.regWrite, 0);
        check("midld_late_err",      bus.err,      1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: DEPTH, 4, pending-write FIFO entries (power of two, 2..16).
REQ-002 Single clock domain; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock, shared with RegFile.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 alu_valid  in  1  ALU result present this cycle.
REQ-006 alu_dest  in  3  ALU destination register.
REQ-007 alu_result  in  8  ALU result data.
REQ-008 ld_issue  in  1  load issued to data memory this cycle.
REQ-009 ld_dest  in  3  load destination register.
REQ-010 mem_rvalid  in  1  data memory returns load data this cycle.
REQ-011 mem_rdata  in  8  load data.
REQ-012 rd_reg1, rd_reg2  in  3 each  decode-stage RegFile read addresses.
REQ-013 regWrite  out  1  RegFile write enable (registered).
REQ-014 writeReg  out  3  RegFile write address (registered).
REQ-015 writeData  out  8  RegFile write data (registered).
REQ-016 stall  out  1  hold decode/issue (combinational).
REQ-017 err  out  1  sticky protocol/overflow error.

Function
REQ-018 Load tracker SHALL have states IDLE and WAIT_MEM; ld_issue in IDLE -> WAIT_MEM, latching ld_dest.
REQ-019 In WAIT_MEM, mem_rvalid SHALL enqueue {latched dest, mem_rdata} and return to IDLE, unless ld_issue is also high, then stay WAIT_MEM with new ld_dest latched.
REQ-020 ld_issue in WAIT_MEM without mem_rvalid SHALL be ignored and set err; mem_rvalid in IDLE SHALL be ignored and set err.
REQ-021 Same-cycle load return and alu_valid SHALL enqueue load entry first, ALU entry second.
REQ-022 Output register SHALL load from FIFO head when FIFO non-empty, else directly from a single same-cycle event (bypass), else regWrite=0.
REQ-023 Latency: lone event at edge N with empty FIFO SHALL give regWrite=1 during cycle N to N+1, i.e. RegFile write at edge N+1.
REQ-024 Exactly one write per cycle; order of writes SHALL equal enqueue order.
REQ-025 Enqueue while FIFO full (after same-cycle pop) SHALL drop the entry and set err; FIFO pointers wrap modulo DEPTH.
REQ-026 stall SHALL be 1 when FIFO count >= DEPTH-1.
REQ-027 stall SHALL be 1 when rd_reg1 or rd_reg2 equals the dest of any valid FIFO entry, the output register while regWrite=1, or the latched load dest in WAIT_MEM.
REQ-028 When regWrite=0, writeReg and writeData SHALL hold previous values.
REQ-029 err SHALL remain 1 until reset.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set state IDLE, FIFO empty, regWrite=0, writeReg=0, writeData=0, err=0.
REQ-031 Reset mid-load SHALL discard the outstanding load; later mem_rvalid in IDLE sets err.
REQ-032 Reset SHALL override all same-cycle inputs.

Verification
REQ-033 alu_valid, dest=3, result=0x5A at edge 1 -> regWrite=1, writeReg=3, writeData=0x5A in cycle after edge 1; 0x5A in reg 3 after edge 2.
REQ-034 ld_issue dest=5; rd_reg1=5 next cycle -> stall=1; mem_rvalid data=0xC3 -> reg 5 written 0xC3, stall=0 once written.
REQ-035 mem_rvalid (dest 2, 0x11) with alu_valid (dest 4, 0x22) same edge -> writes reg2=0x11 then reg4=0x22 on consecutive cycles.
REQ-036 DEPTH=4, ALU+load results every cycle for 6 cycles -> stall=1 at count 3, overflow drop sets err=1, no reordering of accepted entries.
REQ-037 mem_rvalid with no load outstanding -> no write, err=1; rst_n=0 one edge -> err=0, regWrite=0, stall=0.
